dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Two-port arbiter and access sequencer in front of the single-ported data memory (combinational read, write on clock edge).
- Port 0 serves the core load/store unit; port 1 serves a debug/DMA requester.
- Arbitrates round-robin and performs byte/halfword stores as a merged read-modify-write word write.
- Extracts and sign- or zero-extends sub-word loads, and rejects misaligned accesses with an error acknowledge.

Parameters:
- FIRST_PRIO, 0, port that wins the first simultaneous request after reset (0 or 1).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous active-high reset.
- req0 / req1  in  1  request; held high with stable attributes until the matching ack.
- we0 / we1  in  1  1 = store, 0 = load.
- addr0 / addr1  in  32  byte address.
- wdata0 / wdata1  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- size0 / size1  in  2  00 byte, 01 half, 10 word; 11 is illegal.
- uns0 / uns1  in  1  load zero-extend when 1, sign-extend when 0.
- ack0 / ack1  out  1  one-cycle completion pulse.
- err0 / err1  out  1  valid with ack; 1 = misaligned or illegal size, no memory effect.
- rdata0 / rdata1  out  32  load result, valid with ack; holds its last value otherwise.
- mem_addr  out  32  memory address; word aligned, bits [1:0] = 0.
- mem_wdata  out  32  merged write word.
- mem_we  out  1  memory write enable.
- mem_rdata  in  32  memory combinational read data.

Behaviour:
- States: IDLE, ACCESS, DONE (registered).
- Reset values: state=IDLE, last_grant=~FIRST_PRIO. ack0/1=0, err0/1=0, rdata0/1=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Reset is asynchronous and may hit any state: the transaction is abandoned. mem_we drops immediately because it is decoded from the state. No partial write can occur after reset asserts.
- IDLE:
  - Only one req high: grant that port.
  - Both high: grant the port that is not last_grant.
  - On grant: latch port id, we, addr, wdata, size, uns; update last_grant; go to ACCESS.
  - No req: stay in IDLE with memory outputs at 0.
- ACCESS (one cycle):
  - mem_addr = {latched_addr[31:2], 2'b00}.
  - Alignment check. Error if size=11, or size=01 and addr[0]=1, or size=10 and addr[1:0]!=0. On error, mem_we=0.
  - Legal store: mem_we=1. mem_wdata = mem_rdata with the addressed byte or half replaced by the low bits of wdata. For a word, mem_wdata = wdata. Byte lane = addr[1:0]; half lane = addr[1].
  - Legal load: select the lane from mem_rdata, extend per uns, and register into the granted port's rdata. The other port's rdata is unchanged.
  - Next state is DONE.
- DONE (one cycle):
  - Granted port ack=1, and err = the latched error flag.
  - The other port's ack and err stay 0; next state is IDLE.
- Latency: request to ack is 2 cycles, and each transaction occupies 3 cycles (IDLE, ACCESS, DONE).
- Requesters must deassert req in the cycle after ack, or a new transaction starts.
- A port whose request is pending is served within at most one other transaction (starvation freedom).
- Requests that change before ack are undefined; the arbiter uses the latched copy.
- Address bits above [1:0] are passed through without bounds checks; wrapping is done by memory decode.
- ack0 and ack1 are never high in the same cycle.

Test Plan:
- Word path: port 0 stores 0xDEADBEEF to addr 0x10, then loads 0x10 -> mem_we high only in the ACCESS cycle; ack0 two cycles after req; rdata0=0xDEADBEEF, err0=0.
- Sub-word store: word at 0x20 = 0x11223344; port 1 stores byte 0xAA at 0x21 -> memory word = 0x1122AA44. Then a half 0x5566 at 0x22 -> word = 0x5566AA44.
- Sub-word load with extension: word at 0x30 = 0x80F0017F.
  - Byte at 0x33, uns=0 -> 0xFFFFFF80.
  - Byte at 0x33, uns=1 -> 0x00000080.
  - Half at 0x32, uns=0 -> 0xFFFF80F0.
  - Byte at 0x30, uns=0 -> 0x0000007F.
- Contention: req0 and req1 held continuously -> grants alternate. After reset with FIRST_PRIO=0 the order is 0,1,0,1. Never two consecutive grants to the same port while the other is pending.
- Errors: word store to 0x12 and half load from 0x05 -> ack with err=1. mem_we never asserts, and the memory contents are unchanged.
- Reset mid-access: assert rst during ACCESS of a store -> mem_we falls without a clock edge; state=IDLE, no ack is issued, and the target word is unchanged.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port round-robin arbiter and access sequencer for a
// single-ported data memory. Each transaction takes three cycles:
// grant (IDLE), memory access (ACCESS), and acknowledge (DONE).
// Sub-word stores are merged into the read word and written back in the
// same cycle. Sub-word loads are lane-selected and then sign- or
// zero-extended. A misaligned access or an illegal size gets an error
// acknowledge and leaves memory untouched.
module dmem_arbiter #(
    parameter int FIRST_PRIO = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        we0,
    input  logic [31:0] addr0,
    input  logic [31:0] wdata0,
    input  logic [1:0]  size0,
    input  logic        uns0,
    output logic        ack0,
    output logic        err0,
    output logic [31:0] rdata0,
    input  logic        req1,
    input  logic        we1,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata1,
    input  logic [1:0]  size1,
    input  logic        uns1,
    output logic        ack1,
    output logic        err1,
    output logic [31:0] rdata1,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    // last_grant starts at the port that must lose the first tie
    localparam logic LAST_GRANT_RST = (FIRST_PRIO == 0) ? 1'b1 : 1'b0;

    state_t      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic        port_q, port_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic        ack0_q, ack0_d;
    logic        ack1_q, ack1_d;
    logic        err0_q, err0_d;
    logic        err1_q, err1_d;
    logic [31:0] rdata0_q, rdata0_d;
    logic [31:0] rdata1_q, rdata1_d;

    logic        in_access;
    logic        misalign;
    logic        grant;
    logic [31:0] merged;
    logic [31:0] shifted;
    logic [31:0] load_val;

    assign in_access = (state_q == S_ACCESS);

    // Alignment / legal-size check on the latched request
    always_comb begin
        misalign = 1'b0;
        case (size_q)
            2'b00:   misalign = 1'b0;
            2'b01:   misalign = addr_q[0];
            2'b10:   misalign = (addr_q[1:0] != 2'b00);
            default: misalign = 1'b1;
        endcase
    end

    // Memory-side outputs are decoded from the state, so an asynchronous
    // reset drops mem_we at once and cannot let a partial write through.
    assign mem_we    = in_access && we_q && !misalign;
    assign mem_addr  = in_access ? {addr_q[31:2], 2'b00} : 32'd0;
    assign mem_wdata = mem_we ? merged : 32'd0;

    // Read-modify-write merge: replace the addressed lane of the read word
    always_comb begin
        merged = mem_rdata;
        case (size_q)
            2'b00:   merged[{addr_q[1:0], 3'b000} +: 8]  = wdata_q[7:0];
            2'b01:   merged[{addr_q[1], 4'b0000} +: 16]  = wdata_q[15:0];
            default: merged = wdata_q;
        endcase
    end

    // Load lane select and extension. A legal half always has addr[0]=0,
    // so a byte-granular shift also lines up the half lane.
    always_comb begin
        shifted  = mem_rdata >> {addr_q[1:0], 3'b000};
        load_val = mem_rdata;
        case (size_q)
            2'b00:   load_val = uns_q ? {24'd0, shifted[7:0]}
                                      : {{24{shifted[7]}}, shifted[7:0]};
            2'b01:   load_val = uns_q ? {16'd0, shifted[15:0]}
                                      : {{16{shifted[15]}}, shifted[15:0]};
            default: load_val = mem_rdata;
        endcase
    end

    // Round-robin pick: a lone requester wins, a tie goes to the port
    // that was not granted last
    always_comb begin
        if (req0 && req1)
            grant = ~last_grant_q;
        else
            grant = req1;
    end

    // Sequencer next-state and registered-output computation
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        port_d       = port_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        size_d       = size_q;
        uns_d        = uns_q;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        err0_d       = 1'b0;
        err1_d       = 1'b0;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    port_d       = grant;
                    last_grant_d = grant;
                    we_d         = grant ? we1    : we0;
                    addr_d       = grant ? addr1  : addr0;
                    wdata_d      = grant ? wdata1 : wdata0;
                    size_d       = grant ? size1  : size0;
                    uns_d        = grant ? uns1   : uns0;
                    state_d      = S_ACCESS;
                end
            end
            S_ACCESS: begin
                // ack/err are registered here so they appear during DONE
                if (port_q) begin
                    ack1_d = 1'b1;
                    err1_d = misalign;
                    if (!misalign && !we_q)
                        rdata1_d = load_val;
                end else begin
                    ack0_d = 1'b1;
                    err0_d = misalign;
                    if (!misalign && !we_q)
                        rdata0_d = load_val;
                end
                state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers, asynchronously cleared
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            last_grant_q <= LAST_GRANT_RST;
            port_q       <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            size_q       <= 2'b00;
            uns_q        <= 1'b0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            err0_q       <= 1'b0;
            err1_q       <= 1'b0;
            rdata0_q     <= 32'd0;
            rdata1_q     <= 32'd0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            port_q       <= port_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            err0_q       <= err0_d;
            err1_q       <= err1_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
        end
    end

    assign ack0   = ack0_q;
    assign ack1   = ack1_q;
    assign err0   = err0_q;
    assign err1   = err1_q;
    assign rdata0 = rdata0_q;
    assign rdata1 = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a transaction-level reference model with a
// per-cycle compare process, plus directed vectors with literal results.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, we0, uns0, req1, we1, uns1;
    logic [31:0] addr0, wdata0, addr1, wdata1;
    logic [1:0]  size0, size1;
    logic        ack0, err0, ack1, err1;
    logic [31:0] rdata0, rdata1;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we;
    logic        mem_clr;

    int vectors = 0;
    int miscompares = 0;

    dmem_arbiter #(.FIRST_PRIO(0)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .size0(size0), .uns0(uns0),
        .ack0(ack0), .err0(err0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .size1(size1), .uns1(uns1),
        .ack1(ack1), .err1(err1), .rdata1(rdata1),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory: combinational read, write on the clock edge
    logic [31:0] mem [0:63];
    assign mem_rdata = mem[mem_addr[7:2]];
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'd0;
        end else if (mem_we) begin
            mem[mem_addr[7:2]] <= mem_wdata;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic f_legal(logic [31:0] a, logic [1:0] sz);
        if (sz == 2'd0) return 1'b1;
        if (sz == 2'd1) return (a % 2) == 0;
        if (sz == 2'd2) return (a % 4) == 0;
        return 1'b0;
    endfunction

    function automatic logic [31:0] f_load(logic [31:0] w, logic [31:0] a, logic [1:0] sz, logic u);
        logic [31:0] v;
        v = w >> (8 * (a % 4));
        if (sz == 2'd0) begin
            v = v % 256;
            if (!u && v >= 128) v = v + 32'hFFFFFF00;
        end else if (sz == 2'd1) begin
            v = v % 65536;
            if (!u && v >= 32768) v = v + 32'hFFFF0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic logic [31:0] f_merge(logic [31:0] w, logic [31:0] a, logic [1:0] sz, logic [31:0] d);
        logic [31:0] mask;
        int sh;
        if (sz == 2'd0) begin
            sh = 8 * (a % 4);
            mask = 32'hFF << sh;
            return (w & ~mask) | ((d & 32'hFF) << sh);
        end else if (sz == 2'd1) begin
            sh = ((a % 4) >= 2) ? 16 : 0;
            mask = 32'hFFFF << sh;
            return (w & ~mask) | ((d & 32'hFFFF) << sh);
        end
        return d;
    endfunction

    logic [31:0] ref_mem [0:63];
    int          m_phase;          // 0 idle, 1 access cycle, 2 ack cycle
    int          m_last;
    int          m_g;
    logic        m_we, m_legal;
    logic [31:0] m_addr, m_wdata_exp;
    logic [1:0]  m_size;
    logic        m_uns;
    logic [31:0] m_rd [2];

    initial for (int i = 0; i < 64; i++) ref_mem[i] = 32'd0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase = 0;
            m_last  = 1;
            m_rd[0] = 32'd0;
            m_rd[1] = 32'd0;
        end else begin
            if (m_phase == 0) begin
                if (req0 || req1) begin
                    if (req0 && req1) m_g = (m_last == 0) ? 1 : 0;
                    else              m_g = req1 ? 1 : 0;
                    m_last  = m_g;
                    m_we    = m_g ? we1 : we0;
                    m_addr  = m_g ? addr1 : addr0;
                    m_size  = m_g ? size1 : size0;
                    m_uns   = m_g ? uns1 : uns0;
                    m_legal = f_legal(m_addr, m_size);
                    m_wdata_exp = f_merge(ref_mem[m_addr[7:2]], m_addr, m_size,
                                          m_g ? wdata1 : wdata0);
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                if (m_legal && m_we)  ref_mem[m_addr[7:2]] = m_wdata_exp;
                if (m_legal && !m_we) m_rd[m_g] = f_load(ref_mem[m_addr[7:2]], m_addr, m_size, m_uns);
                m_phase = 2;
            end else begin
                m_phase = 0;
            end
        end
    end

    // Per-cycle compare of every output against the model
    always @(negedge clk) begin
        if (!rst) begin
            logic wexp;
            wexp = (m_phase == 1) && m_we && m_legal;
            chk("ack0", {31'd0, ack0}, {31'd0, (m_phase == 2 && m_g == 0)});
            chk("ack1", {31'd0, ack1}, {31'd0, (m_phase == 2 && m_g == 1)});
            chk("err0", {31'd0, err0}, {31'd0, (m_phase == 2 && m_g == 0 && !m_legal)});
            chk("err1", {31'd0, err1}, {31'd0, (m_phase == 2 && m_g == 1 && !m_legal)});
            chk("rdata0", rdata0, m_rd[0]);
            chk("rdata1", rdata1, m_rd[1]);
            chk("mem_we", {31'd0, mem_we}, {31'd0, wexp});
            chk("mem_addr", mem_addr, (m_phase == 1) ? {m_addr[31:2], 2'b00} : 32'd0);
            chk("mem_wdata", mem_wdata, wexp ? m_wdata_exp : 32'd0);
            chk("ack_excl", {31'd0, (ack0 && ack1)}, 32'd0);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic txn(input int p, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] sz, input logic u,
                       output logic [31:0] rd, output logic er, output int lat);
        logic got;
        @(negedge clk);
        if (p == 0) begin
            req0 = 1; we0 = w; addr0 = a; wdata0 = d; size0 = sz; uns0 = u;
        end else begin
            req1 = 1; we1 = w; addr1 = a; wdata1 = d; size1 = sz; uns1 = u;
        end
        got = 0;
        lat = 0;
        while (!got && lat < 10) begin
            @(negedge clk);
            lat++;
            got = (p == 0) ? ack0 : ack1;
        end
        chk("ack_seen", {31'd0, got}, 32'd1);
        rd = (p == 0) ? rdata0 : rdata1;
        er = (p == 0) ? err0 : err1;
        req0 = 0;
        req1 = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1;
        repeat (2) @(negedge clk);
        rst = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          order [4];
        int          n;

        rst = 1; mem_clr = 1;
        req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0; size0 = 0; uns0 = 0;
        req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0; size1 = 0; uns1 = 0;
        repeat (3) @(negedge clk);
        chk("rst_ack0", {31'd0, ack0}, 32'd0);
        chk("rst_ack1", {31'd0, ack1}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_rdata0", rdata0, 32'd0);
        chk("rst_rdata1", rdata1, 32'd0);
        rst = 0; mem_clr = 0;

        // word path
        txn(0, 1, 32'h10, 32'hDEADBEEF, 2'd2, 0, rd, er, lat);
        chk("wstore_lat", lat, 2);
        chk("wstore_err", {31'd0, er}, 32'd0);
        txn(0, 0, 32'h10, 32'd0, 2'd2, 0, rd, er, lat);
        chk("wload_lat", lat, 2);
        chk("wload_data", rd, 32'hDEADBEEF);
        chk("wload_err", {31'd0, er}, 32'd0);

        // sub-word stores
        txn(1, 1, 32'h20, 32'h11223344, 2'd2, 0, rd, er, lat);
        txn(1, 1, 32'h21, 32'h000000AA, 2'd0, 0, rd, er, lat);
        chk("bstore_mem", mem[8], 32'h1122AA44);
        txn(1, 1, 32'h22, 32'h00005566, 2'd1, 0, rd, er, lat);
        chk("hstore_mem", mem[8], 32'h5566AA44);

        // sub-word loads with extension
        txn(0, 1, 32'h30, 32'h80F0017F, 2'd2, 0, rd, er, lat);
        txn(1, 0, 32'h33, 32'd0, 2'd0, 0, rd, er, lat);
        chk("lb_s_33", rd, 32'hFFFFFF80);
        txn(1, 0, 32'h33, 32'd0, 2'd0, 1, rd, er, lat);
        chk("lb_u_33", rd, 32'h00000080);
        txn(1, 0, 32'h32, 32'd0, 2'd1, 0, rd, er, lat);
        chk("lh_s_32", rd, 32'hFFFF80F0);
        txn(0, 0, 32'h30, 32'd0, 2'd0, 0, rd, er, lat);
        chk("lb_s_30", rd, 32'h0000007F);

        // misaligned accesses
        txn(0, 1, 32'h12, 32'hCAFEF00D, 2'd2, 0, rd, er, lat);
        chk("err_wstore", {31'd0, er}, 32'd1);
        chk("err_wstore_mem", mem[4], 32'hDEADBEEF);
        txn(1, 0, 32'h05, 32'd0, 2'd1, 0, rd, er, lat);
        chk("err_hload", {31'd0, er}, 32'd1);
        chk("err_hload_rd", rd, 32'hFFFF80F0);
        txn(0, 1, 32'h10, 32'h0, 2'd3, 0, rd, er, lat);
        chk("err_size3", {31'd0, er}, 32'd1);
        chk("err_size3_mem", mem[4], 32'hDEADBEEF);

        // contention right after reset: order must be 0,1,0,1
        do_reset();
        req0 = 1; we0 = 0; addr0 = 32'h10; size0 = 2'd2; uns0 = 0;
        req1 = 1; we1 = 0; addr1 = 32'h20; size1 = 2'd2; uns1 = 0;
        n = 0;
        for (int c = 0; c < 40 && n < 4; c++) begin
            @(negedge clk);
            if (ack0) begin order[n] = 0; n++; end
            else if (ack1) begin order[n] = 1; n++; end
        end
        req0 = 0; req1 = 0;
        chk("cont_count", n, 4);
        chk("cont_g0", order[0], 0);
        chk("cont_g1", order[1], 1);
        chk("cont_g2", order[2], 0);
        chk("cont_g3", order[3], 1);
        chk("cont_rd0", rdata0, 32'hDEADBEEF);
        chk("cont_rd1", rdata1, 32'h5566AA44);

        // reset during the ACCESS cycle of a store
        repeat (2) @(negedge clk);
        req0 = 1; we0 = 1; addr0 = 32'h40; wdata0 = 32'h12345678; size0 = 2'd2; uns0 = 0;
        @(posedge clk);
        #2;
        chk("mid_we_before", {31'd0, mem_we}, 32'd1);
        rst = 1;
        #1;
        chk("mid_we_async", {31'd0, mem_we}, 32'd0);
        chk("mid_addr_async", mem_addr, 32'd0);
        req0 = 0;
        repeat (2) @(negedge clk);
        chk("mid_ack0", {31'd0, ack0}, 32'd0);
        rst = 0;
        repeat (3) @(negedge clk);
        chk("mid_mem", mem[16], 32'd0);
        chk("mid_state_idle_we", {31'd0, mem_we}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
